// File: rtl/conv2_cu.sv
// Control unit for the second convolution layer: sequences weight loads, IFM streaming,
// window/MAC enables and output writes per (filter, depth) pass, with bank handshakes.
module conv2_cu #(
  parameter int DATA_WIDTH            = 32,
  parameter int IFM_SIZE              = 14,
  parameter int IFM_DEPTH             = 6,
  parameter int KERNAL_SIZE           = 5,
  parameter int NUMBER_OF_FILTERS     = 16,
  parameter int PIPE_LATENCY          = 4,
  parameter int IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
  parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE * IFM_DEPTH),
  parameter int ADDRESS_SIZE_WM       =
      $clog2(KERNAL_SIZE * KERNAL_SIZE * IFM_DEPTH * NUMBER_OF_FILTERS),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_from_previous,
  input  logic                             end_from_next,
  output logic                             end_to_previous,
  output logic                             ifm_sel_current,
  output logic                             ifm_enable_read_current,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_current,
  output logic                             wm_enable_read,
  output logic [ADDRESS_SIZE_WM-1:0]       wm_address_read,
  output logic                             fifo_enable,
  output logic                             conv_enable,
  output logic                             ofm_accumulate,
  output logic                             ifm_enable_write_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
  output logic                             start_to_next,
  output logic                             ifm_sel_next
);

  localparam int K2       = KERNAL_SIZE * KERNAL_SIZE;
  localparam int S2       = IFM_SIZE * IFM_SIZE;
  localparam int N2       = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
  localparam int DrainLen = PIPE_LATENCY + 2;
  localparam int CntMax   = (S2 > DrainLen) ? S2 : DrainLen;
  localparam int CW       = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int DW       = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
  localparam int FW       = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1;
  localparam int RW       = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
  localparam int IW       = ADDRESS_SIZE_IFM;
  localparam int WW       = ADDRESS_SIZE_WM;
  localparam int NW       = ADDRESS_SIZE_NEXT_IFM;

  localparam logic [CW-1:0] LoadLast  = CW'(K2 - 1);
  localparam logic [CW-1:0] ReadLast  = CW'(S2 - 1);
  localparam logic [CW-1:0] DrainLast = CW'(DrainLen - 1);
  localparam logic [DW-1:0] DepthLast = DW'(IFM_DEPTH - 1);
  localparam logic [FW-1:0] FiltLast  = FW'(NUMBER_OF_FILTERS - 1);
  localparam logic [RW-1:0] PixLast   = RW'(IFM_SIZE - 1);
  localparam logic [RW-1:0] WinFirst  = RW'(KERNAL_SIZE - 1);
  localparam logic [NW-1:0] WrLast    = NW'(N2 - 1);

  if (DATA_WIDTH < 1 || KERNAL_SIZE > IFM_SIZE || PIPE_LATENCY < 1) begin : g_bad_params
    $error("conv2_cu: invalid parameter set");
  end

  typedef enum logic [2:0] {StIdle, StLoadW, StRead, StDrain, StWaitNext, StFinish} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DW-1:0]           d_q, d_d;
  logic [FW-1:0]           f_q, f_d;
  logic [WW-1:0]           wm_addr_q, wm_addr_d;
  logic [IW-1:0]           ifm_addr_q, ifm_addr_d;
  logic                    sel_cur_q, sel_cur_d;
  logic                    sel_next_q, sel_next_d;
  logic                    fifo_q, conv_q;
  logic [RW-1:0]           row_q, col_q;
  logic [PIPE_LATENCY-1:0] pipe_q;
  logic [PIPE_LATENCY:0]   pipe_ext;
  logic [NW-1:0]           wr_addr_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    d_d           = d_q;
    f_d           = f_q;
    wm_addr_d     = wm_addr_q;
    ifm_addr_d    = ifm_addr_q;
    sel_cur_d     = sel_cur_q;
    sel_next_d    = sel_next_q;
    start_to_next = 1'b0;
    case (state_q)
      StIdle, StFinish: begin
        if (start_from_previous) begin
          state_d    = StLoadW;
          cnt_d      = '0;
          d_d        = '0;
          f_d        = '0;
          wm_addr_d  = '0;
          ifm_addr_d = '0;
        end
      end
      StLoadW: begin
        if (cnt_q == LoadLast) begin
          state_d = StRead;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          wm_addr_d = wm_addr_q + WW'(1);
        end
      end
      StRead: begin
        if (cnt_q == ReadLast) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          ifm_addr_d = ifm_addr_q + IW'(1);
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          cnt_d = '0;
          // Weight and IFM addresses run on contiguously into the next depth slice.
          if (d_q != DepthLast) begin
            state_d    = StLoadW;
            d_d        = d_q + DW'(1);
            wm_addr_d  = wm_addr_q + WW'(1);
            ifm_addr_d = ifm_addr_q + IW'(1);
          end else begin
            state_d    = StWaitNext;
            d_d        = '0;
            ifm_addr_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWaitNext: begin
        if (end_from_next) begin
          start_to_next = 1'b1;
          sel_next_d    = ~sel_next_q;
          if (f_q != FiltLast) begin
            state_d   = StLoadW;
            f_d       = f_q + FW'(1);
            wm_addr_d = wm_addr_q + WW'(1);
          end else begin
            state_d   = StFinish;
            sel_cur_d = ~sel_cur_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pipe_ext = {pipe_q, conv_q};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      d_q        <= '0;
      f_q        <= '0;
      wm_addr_q  <= '0;
      ifm_addr_q <= '0;
      sel_cur_q  <= 1'b0;
      sel_next_q <= 1'b0;
      fifo_q     <= 1'b0;
      conv_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      pipe_q     <= '0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_q        <= d_d;
      f_q        <= f_d;
      wm_addr_q  <= wm_addr_d;
      ifm_addr_q <= ifm_addr_d;
      sel_cur_q  <= sel_cur_d;
      sel_next_q <= sel_next_d;
      fifo_q     <= (state_q == StRead);
      // row/col index the pixel being pushed this cycle; a full window ends at it.
      conv_q     <= fifo_q && (row_q >= WinFirst) && (col_q >= WinFirst);
      if (fifo_q) begin
        if (col_q == PixLast) begin
          col_q <= '0;
          row_q <= (row_q == PixLast) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + RW'(1);
        end
      end
      pipe_q <= pipe_ext[PIPE_LATENCY-1:0];
      if (pipe_q[PIPE_LATENCY-1]) begin
        wr_addr_q <= (wr_addr_q == WrLast) ? '0 : wr_addr_q + NW'(1);
      end
    end
  end

  assign end_to_previous          = (state_q == StIdle) || (state_q == StFinish);
  assign ifm_sel_current          = sel_cur_q;
  assign ifm_enable_read_current  = (state_q == StRead);
  assign ifm_address_read_current = ifm_addr_q;
  assign wm_enable_read           = (state_q == StLoadW);
  assign wm_address_read          = wm_addr_q;
  assign fifo_enable              = fifo_q;
  assign conv_enable              = conv_q;
  assign ifm_enable_write_next    = pipe_q[PIPE_LATENCY-1];
  assign ofm_accumulate           = pipe_q[PIPE_LATENCY-1] && (d_q != '0);
  assign ifm_address_write_next   = wr_addr_q;
  assign ifm_sel_next             = sel_next_q;

endmodule

// File: tb/tb_conv2_cu.sv
// Directed bench for conv2_cu (6x6 IFM, 3x3 kernel, depth 2, 2 filters, latency 2):
// every cycle of each pass is compared against a hand-derived timeline.
module tb_conv2_cu;
  localparam int S  = 6;
  localparam int K  = 3;
  localparam int D  = 2;
  localparam int NF = 2;
  localparam int L  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_from_previous;
  logic       end_from_next;
  logic       end_to_previous;
  logic       ifm_sel_current;
  logic       ifm_enable_read_current;
  logic [6:0] ifm_address_read_current;
  logic       wm_enable_read;
  logic [5:0] wm_address_read;
  logic       fifo_enable;
  logic       conv_enable;
  logic       ofm_accumulate;
  logic       ifm_enable_write_next;
  logic [3:0] ifm_address_write_next;
  logic       start_to_next;
  logic       ifm_sel_next;

  conv2_cu #(
    .IFM_SIZE(S), .IFM_DEPTH(D), .KERNAL_SIZE(K), .NUMBER_OF_FILTERS(NF), .PIPE_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset),
    .start_from_previous(start_from_previous), .end_from_next(end_from_next),
    .end_to_previous(end_to_previous), .ifm_sel_current(ifm_sel_current),
    .ifm_enable_read_current(ifm_enable_read_current),
    .ifm_address_read_current(ifm_address_read_current),
    .wm_enable_read(wm_enable_read), .wm_address_read(wm_address_read),
    .fifo_enable(fifo_enable), .conv_enable(conv_enable), .ofm_accumulate(ofm_accumulate),
    .ifm_enable_write_next(ifm_enable_write_next),
    .ifm_address_write_next(ifm_address_write_next),
    .start_to_next(start_to_next), .ifm_sel_next(ifm_sel_next)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel_cur_exp = 0;
  int sel_next_exp = 0;
  int wr_exp = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " end_to_previous"}, 32'(end_to_previous), 1);
    chk({tag, " wm_en"}, 32'(wm_enable_read), 0);
    chk({tag, " wm_addr"}, 32'(wm_address_read), 0);
    chk({tag, " ifm_en"}, 32'(ifm_enable_read_current), 0);
    chk({tag, " ifm_addr"}, 32'(ifm_address_read_current), 0);
    chk({tag, " fifo"}, 32'(fifo_enable), 0);
    chk({tag, " conv"}, 32'(conv_enable), 0);
    chk({tag, " write"}, 32'(ifm_enable_write_next), 0);
    chk({tag, " wr_addr"}, 32'(ifm_address_write_next), 0);
    chk({tag, " accum"}, 32'(ofm_accumulate), 0);
    chk({tag, " start_to_next"}, 32'(start_to_next), 0);
    chk({tag, " sel_cur"}, 32'(ifm_sel_current), sel_cur_exp);
    chk({tag, " sel_next"}, 32'(ifm_sel_next), sel_next_exp);
  endtask

  // One pass: t=0..8 weight load, t=9..44 IFM read, t=45..48 drain.
  // Push p happens at t=p+10, its conv at p+11, its write at p+13.
  task automatic run_pass(input int d, input int f, input int stop_t, input int hold);
    wr_exp = 0;
    for (int t = 0; t < 49; t++) begin
      int    wm_en, ifm_en, fifo, conv, wr, p, q;
      string ctx;
      ctx    = $sformatf("f%0d d%0d t%0d", f, d, t);
      wm_en  = (t < 9) ? 1 : 0;
      ifm_en = (t >= 9 && t < 45) ? 1 : 0;
      fifo   = (t >= 10 && t < 46) ? 1 : 0;
      p      = t - 11;
      conv   = (p >= 0 && p < 36 && p / S >= K - 1 && p % S >= K - 1) ? 1 : 0;
      q      = t - 13;
      wr     = (q >= 0 && q < 36 && q / S >= K - 1 && q % S >= K - 1) ? 1 : 0;
      chk({"wm_en ", ctx}, 32'(wm_enable_read), wm_en);
      if (wm_en != 0) chk({"wm_addr ", ctx}, 32'(wm_address_read), (f * D + d) * K * K + t);
      chk({"ifm_en ", ctx}, 32'(ifm_enable_read_current), ifm_en);
      if (ifm_en != 0) chk({"ifm_addr ", ctx}, 32'(ifm_address_read_current), d * S * S + t - 9);
      chk({"fifo ", ctx}, 32'(fifo_enable), fifo);
      chk({"conv ", ctx}, 32'(conv_enable), conv);
      chk({"write ", ctx}, 32'(ifm_enable_write_next), wr);
      chk({"accum ", ctx}, 32'(ofm_accumulate), (wr != 0 && d != 0) ? 1 : 0);
      if (wr != 0) begin
        chk({"wr_addr ", ctx}, 32'(ifm_address_write_next), wr_exp);
        wr_exp++;
      end
      chk({"start_to_next ", ctx}, 32'(start_to_next), 0);
      chk({"end_to_previous ", ctx}, 32'(end_to_previous), 0);
      chk({"sel_cur ", ctx}, 32'(ifm_sel_current), sel_cur_exp);
      chk({"sel_next ", ctx}, 32'(ifm_sel_next), sel_next_exp);
      if (t == stop_t) return;
      start_from_previous = hold[0];
      step();
    end
  endtask

  task automatic run_frame(input int hold, input int wait_first);
    start_from_previous = 1'b1;
    step();
    for (int f = 0; f < NF; f++) begin
      for (int d = 0; d < D; d++) run_pass(d, f, -1, hold);
      if (f == NF - 1) start_from_previous = 1'b0;
      if (wait_first != 0 && f == 0) begin
        for (int i = 0; i < 10; i++) begin
          chk($sformatf("wait start_to_next c%0d", i), 32'(start_to_next), 0);
          chk($sformatf("wait write c%0d", i), 32'(ifm_enable_write_next), 0);
          chk($sformatf("wait end_to_previous c%0d", i), 32'(end_to_previous), 0);
          chk($sformatf("wait wm_en c%0d", i), 32'(wm_enable_read), 0);
          chk($sformatf("wait ifm_en c%0d", i), 32'(ifm_enable_read_current), 0);
          step();
        end
        end_from_next = 1'b1;
        #1;
      end
      chk($sformatf("start_to_next pulse f%0d", f), 32'(start_to_next), 1);
      chk($sformatf("sel_next before f%0d", f), 32'(ifm_sel_next), sel_next_exp);
      step();
      sel_next_exp ^= 1;
      chk($sformatf("sel_next after f%0d", f), 32'(ifm_sel_next), sel_next_exp);
      chk($sformatf("start_to_next low after f%0d", f), 32'(start_to_next), 0);
    end
    sel_cur_exp ^= 1;
    chk("finish end_to_previous", 32'(end_to_previous), 1);
    chk("finish sel_cur", 32'(ifm_sel_current), sel_cur_exp);
    chk("finish wm_en", 32'(wm_enable_read), 0);
    chk("finish ifm_en", 32'(ifm_enable_read_current), 0);
  endtask

  initial begin
    reset               = 1'b0;
    start_from_previous = 1'b0;
    end_from_next       = 1'b0;
    repeat (3) step();
    chk_idle("in reset");
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_idle($sformatf("idle c%0d", i));
    end

    // Frame 1: downstream always free.
    end_from_next = 1'b1;
    run_frame(0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("post1 end_to_previous c%0d", i), 32'(end_to_previous), 1);
      chk($sformatf("post1 write c%0d", i), 32'(ifm_enable_write_next), 0);
      chk($sformatf("post1 wm_en c%0d", i), 32'(wm_enable_read), 0);
    end

    // Frame 2: start held high throughout, downstream busy on first WAIT_NEXT entry.
    end_from_next = 1'b0;
    run_frame(1, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("post2 end_to_previous c%0d", i), 32'(end_to_previous), 1);
      chk($sformatf("post2 wm_en c%0d", i), 32'(wm_enable_read), 0);
    end

    // Frame 3: reset while reading IFM address 20.
    end_from_next       = 1'b1;
    start_from_previous = 1'b1;
    step();
    run_pass(0, 0, 29, 0);
    chk("pre-reset ifm_addr", 32'(ifm_address_read_current), 20);
    reset = 1'b0;
    step();
    sel_cur_exp  = 0;
    sel_next_exp = 0;
    chk_idle("mid reset");
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk_idle($sformatf("after reset c%0d", i));
    end

    // Fresh frame after the abort must restart from address 0.
    run_frame(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
